// File: rtl/ide_pkg.sv
// Shared definitions for the IDE management arbiter: request codes, FSM states and register map.
package ide_pkg;

  localparam logic [2:0] REQ_NONE  = 3'b000;
  localparam logic [2:0] REQ_CMD   = 3'b100;
  localparam logic [2:0] REQ_DATA  = 3'b101;
  localparam logic [2:0] REQ_RESET = 3'b110;

  localparam logic [4:0] REG_STATUS = 5'h10;
  localparam logic [4:0] REG_CTRL   = 5'h11;

  // Channel-space offsets with arbiter side effects
  localparam logic [3:0] CH_RELEASE_OFS = 4'd5;
  localparam logic [3:0] CH_BCAST_OFS   = 4'd6;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RELEASE} arb_state_e;
  typedef enum logic [1:0] {RD_NONE, RD_CH0, RD_CH1, RD_REG} rd_src_e;

endpackage

// File: rtl/ide_mgmt_arbiter.sv
// Arbitrates two IDE channels' management ports onto one host port with round-robin grants.
// Optional host-inactivity timeout is enabled by defining IDE_ARB_TIMEOUT_EN.
module ide_mgmt_arbiter
  import ide_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ch0_request,
  input  logic [2:0]  ch1_request,
  input  logic [4:0]  host_address,
  input  logic        host_write,
  input  logic [15:0] host_writedata,
  input  logic        host_read,
  output logic [15:0] host_readdata,
  output logic [3:0]  ch0_mgmt_address,
  output logic        ch0_mgmt_write,
  output logic [15:0] ch0_mgmt_writedata,
  output logic        ch0_mgmt_read,
  input  logic [15:0] ch0_mgmt_readdata,
  output logic [3:0]  ch1_mgmt_address,
  output logic        ch1_mgmt_write,
  output logic [15:0] ch1_mgmt_writedata,
  output logic        ch1_mgmt_read,
  input  logic [15:0] ch1_mgmt_readdata,
  output logic        host_irq
);

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;
  logic        rr_last_q, rr_last_d;
  logic        sel_q, sel_d;
  logic        flag_q, flag_d;
  logic        irq_q;
  rd_src_e     rd_src_q, rd_src_d;
  logic [15:0] reg_rdata_q, reg_rdata_d;

  logic        chan_space;
  logic        target;
  logic        bcast;
  logic        release_wr;
  logic        any_access;
  logic        timeout_hit;
  logic [2:0]  owner_req;
  logic [15:0] status_word;

  always_comb begin
    chan_space  = ~host_address[4];
    target      = (state_q == ST_IDLE) ? sel_q : owner_q;
    bcast       = chan_space & (host_address[3:0] == CH_BCAST_OFS);
    release_wr  = host_write & chan_space & (host_address[3:0] == CH_RELEASE_OFS);
    any_access  = host_write | host_read;
    owner_req   = owner_q ? ch1_request : ch0_request;
    status_word = {8'd0, flag_q, 1'b0, (state_q == ST_GRANT), owner_q, 1'b0, owner_req};
  end

  // Strobes are forced low during reset so a reset mid-transfer cannot leak a write.
  always_comb begin
    ch0_mgmt_address   = host_address[3:0];
    ch1_mgmt_address   = host_address[3:0];
    ch0_mgmt_writedata = host_writedata;
    ch1_mgmt_writedata = host_writedata;
    ch0_mgmt_write     = ~rst & chan_space & host_write & (bcast | ~target);
    ch1_mgmt_write     = ~rst & chan_space & host_write & (bcast | target);
    ch0_mgmt_read      = ~rst & chan_space & host_read & ~target;
    ch1_mgmt_read      = ~rst & chan_space & host_read & target;
  end

`ifdef IDE_ARB_TIMEOUT_EN
  logic [23:0] timer_q, timer_d;

  always_comb begin
    timer_d     = '0;
    timeout_hit = 1'b0;
    if (state_q == ST_GRANT && !any_access) begin
      if (timer_q == TIMEOUT_CYCLES - 24'd1) timeout_hit = 1'b1;
      else timer_d = timer_q + 24'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end
`else
  logic timeout_unused;
  assign timeout_unused = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    sel_d     = sel_q;
    flag_d    = flag_q;
    case (state_q)
      ST_IDLE: begin
        if (ch0_request != REQ_NONE || ch1_request != REQ_NONE) begin
          state_d = ST_GRANT;
          if (ch0_request != REQ_NONE && ch1_request != REQ_NONE) owner_d = ~rr_last_q;
          else owner_d = (ch0_request == REQ_NONE);
        end
      end
      ST_GRANT: begin
        if (release_wr || timeout_hit) begin
          state_d   = ST_RELEASE;
          rr_last_d = owner_q;
        end
        if (timeout_hit) flag_d = 1'b1;
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (host_write && host_address == REG_CTRL) begin
      sel_d = host_writedata[0];
      if (host_writedata[8]) flag_d = 1'b0;
    end
  end

  // Reads return one cycle later; channel data is muxed live by the captured source.
  always_comb begin
    rd_src_d    = RD_NONE;
    reg_rdata_d = '0;
    if (host_read) begin
      if (!chan_space) begin
        rd_src_d = RD_REG;
        if (host_address == REG_STATUS)    reg_rdata_d = status_word;
        else if (host_address == REG_CTRL) reg_rdata_d = {15'd0, sel_q};
      end else begin
        rd_src_d = target ? RD_CH1 : RD_CH0;
      end
    end
  end

  always_comb begin
    case (rd_src_q)
      RD_CH0:  host_readdata = ch0_mgmt_readdata;
      RD_CH1:  host_readdata = ch1_mgmt_readdata;
      RD_REG:  host_readdata = reg_rdata_q;
      default: host_readdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      rr_last_q   <= 1'b1;
      sel_q       <= 1'b0;
      flag_q      <= 1'b0;
      irq_q       <= 1'b0;
      rd_src_q    <= RD_NONE;
      reg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      sel_q       <= sel_d;
      flag_q      <= flag_d;
      irq_q       <= (state_d == ST_GRANT);
      rd_src_q    <= rd_src_d;
      reg_rdata_q <= reg_rdata_d;
    end
  end

  assign host_irq = irq_q;

endmodule

// File: tb/tb_ide_mgmt_arbiter.sv
// Directed bench for ide_mgmt_arbiter: a grant/ownership model checked every cycle plus literal expectations.
module tb_ide_mgmt_arbiter;
  import ide_pkg::*;

`ifdef IDE_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  ch0_request = REQ_NONE, ch1_request = REQ_NONE;
  logic [4:0]  host_address = '0;
  logic        host_write = 1'b0, host_read = 1'b0;
  logic [15:0] host_writedata = '0;
  logic [15:0] host_readdata;
  logic [3:0]  ch0_mgmt_address, ch1_mgmt_address;
  logic        ch0_mgmt_write, ch1_mgmt_write, ch0_mgmt_read, ch1_mgmt_read;
  logic [15:0] ch0_mgmt_writedata, ch1_mgmt_writedata;
  logic [15:0] ch0_mgmt_readdata = 16'hA0A0, ch1_mgmt_readdata = 16'hB1B1;
  logic        host_irq;

  int vectors = 0;
  int miscompares = 0;

  ide_mgmt_arbiter #(.TIMEOUT_CYCLES(24'd16)) dut (
    .clk(clk), .rst(rst),
    .ch0_request(ch0_request), .ch1_request(ch1_request),
    .host_address(host_address), .host_write(host_write),
    .host_writedata(host_writedata), .host_read(host_read),
    .host_readdata(host_readdata),
    .ch0_mgmt_address(ch0_mgmt_address), .ch0_mgmt_write(ch0_mgmt_write),
    .ch0_mgmt_writedata(ch0_mgmt_writedata), .ch0_mgmt_read(ch0_mgmt_read),
    .ch0_mgmt_readdata(ch0_mgmt_readdata),
    .ch1_mgmt_address(ch1_mgmt_address), .ch1_mgmt_write(ch1_mgmt_write),
    .ch1_mgmt_writedata(ch1_mgmt_writedata), .ch1_mgmt_read(ch1_mgmt_read),
    .ch1_mgmt_readdata(ch1_mgmt_readdata),
    .host_irq(host_irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who holds the port, whether a one-cycle cooldown follows a release, and the read result.
  bit          m_held = 0, m_cool = 0, m_owner = 0, m_last = 1, m_sel = 0, m_flag = 0;
  int          m_idle = 0, m_rd_kind = 0;
  logic [15:0] m_rd_val = '0;
  bit          mTgt;
  logic [2:0]  mOreq;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_held = 0; m_cool = 0; m_owner = 0; m_last = 1; m_sel = 0; m_flag = 0;
      m_idle = 0; m_rd_kind = 0; m_rd_val = '0;
    end else begin
      mTgt  = (m_held || m_cool) ? m_owner : m_sel;
      mOreq = m_owner ? ch1_request : ch0_request;
      m_rd_kind = 0;
      if (host_read) begin
        if (host_address[4]) begin
          m_rd_kind = 3;
          if (host_address == 5'h10)      m_rd_val = {8'd0, m_flag, 1'b0, m_held, m_owner, 1'b0, mOreq};
          else if (host_address == 5'h11) m_rd_val = {15'd0, m_sel};
          else                            m_rd_val = 16'h0000;
        end else begin
          m_rd_kind = mTgt ? 2 : 1;
        end
      end
      if (m_cool) m_cool = 0;
      else if (m_held) begin
        if (host_write && !host_address[4] && host_address[3:0] == 4'd5) begin
          m_held = 0; m_cool = 1; m_last = m_owner;
        end else if (TO_EN) begin
          if (host_write || host_read) m_idle = 0;
          else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
              m_held = 0; m_cool = 1; m_last = m_owner; m_flag = 1;
            end
          end
        end
      end else if (ch0_request != 3'b000 || ch1_request != 3'b000) begin
        m_held = 1;
        m_idle = 0;
        if (ch0_request != 3'b000 && ch1_request != 3'b000) m_owner = !m_last;
        else m_owner = (ch0_request == 3'b000);
      end
      if (host_write && host_address == 5'h11) begin
        m_sel = host_writedata[0];
        if (host_writedata[8]) m_flag = 0;
      end
    end
  end

  bit          cTgt, cChs, cBca;
  logic [15:0] cRd;

  always @(negedge clk) begin
    cTgt = (m_held || m_cool) ? m_owner : m_sel;
    cChs = !rst && !host_address[4];
    cBca = (host_address[3:0] == 4'd6);
    case (m_rd_kind)
      1:       cRd = ch0_mgmt_readdata;
      2:       cRd = ch1_mgmt_readdata;
      3:       cRd = m_rd_val;
      default: cRd = 16'h0000;
    endcase
    checkOutput("irq", host_irq, m_held);
    checkOutput("ch0_wr", ch0_mgmt_write, cChs && host_write && (cBca || !cTgt));
    checkOutput("ch1_wr", ch1_mgmt_write, cChs && host_write && (cBca || cTgt));
    checkOutput("ch0_rd", ch0_mgmt_read, cChs && host_read && !cTgt);
    checkOutput("ch1_rd", ch1_mgmt_read, cChs && host_read && cTgt);
    checkOutput("rdata", host_readdata, cRd);
    if (host_write) begin
      checkOutput("ch0_addr", ch0_mgmt_address, host_address[3:0]);
      checkOutput("ch1_wdata", ch1_mgmt_writedata, host_writedata);
    end
  end

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] a, input logic wr, input logic [15:0] wd, input logic rd);
    host_address = a; host_write = wr; host_writedata = wd; host_read = rd;
    stepCycles(1);
    host_write = 1'b0; host_read = 1'b0;
  endtask

  task automatic readReg(input logic [4:0] a, output logic [15:0] d);
    applyStimulus(a, 1'b0, 16'h0000, 1'b1);
    d = host_readdata;
  endtask

  logic [15:0] rv;

  initial begin
    stepCycles(2);
    checkOutput("reset_irq", host_irq, 16'h0000);
    checkOutput("reset_rdata", host_readdata, 16'h0000);
    rst = 1'b0;
    readReg(5'h10, rv); checkOutput("reset_status", rv, 16'h0000);

    // Broadcast from IDLE
    host_address = 5'h06; host_write = 1'b1; host_writedata = 16'h0289; #1;
    checkOutput("idle_bc_w0", ch0_mgmt_write, 1);
    checkOutput("idle_bc_w1", ch1_mgmt_write, 1);
    stepCycles(1); host_write = 1'b0;

    // Single request: ch0 wins in one cycle
    ch0_request = REQ_CMD;
    stepCycles(1);
    checkOutput("grant_irq", host_irq, 1);
    readReg(5'h10, rv); checkOutput("status_ch0", rv, 16'h0024);

    host_address = 5'h06; host_write = 1'b1; host_writedata = 16'h0289; #1;
    checkOutput("grant_bc_w0", ch0_mgmt_write, 1);
    checkOutput("grant_bc_w1", ch1_mgmt_write, 1);
    stepCycles(1); host_write = 1'b0;

    // Code change and drop keep the grant
    ch0_request = REQ_DATA;
    readReg(5'h10, rv); checkOutput("status_data", rv, 16'h0025);
    ch0_request = REQ_NONE;
    readReg(5'h10, rv); checkOutput("status_drop", rv, 16'h0020);
    checkOutput("drop_irq", host_irq, 1);

    applyStimulus(5'h05, 1'b1, 16'h0000, 1'b0);
    checkOutput("release_irq", host_irq, 0);
    stepCycles(1);

    // Both requesting from reset: ch0 first, then ch1
    rst = 1'b1; ch0_request = REQ_CMD; ch1_request = REQ_CMD;
    stepCycles(1); rst = 1'b0;
    stepCycles(1);
    readReg(5'h10, rv); checkOutput("rr_first", rv, 16'h0024);
    applyStimulus(5'h05, 1'b1, 16'h0000, 1'b0);
    stepCycles(2);
    readReg(5'h10, rv); checkOutput("rr_second", rv, 16'h0034);

    host_address = 5'h02; host_write = 1'b1; host_writedata = 16'h1234; #1;
    checkOutput("own1_w1", ch1_mgmt_write, 1);
    checkOutput("own1_w0", ch0_mgmt_write, 0);
    checkOutput("own1_wd", ch1_mgmt_writedata, 16'h1234);
    stepCycles(1); host_write = 1'b0;
    readReg(5'h03, rv); checkOutput("own1_rdata", rv, 16'hB1B1);

    // Release, then IDLE forwarding follows sel
    applyStimulus(5'h05, 1'b1, 16'h0000, 1'b0);
    ch0_request = REQ_NONE; ch1_request = REQ_NONE;
    stepCycles(1);
    applyStimulus(5'h11, 1'b1, 16'h0001, 1'b0);
    readReg(5'h11, rv); checkOutput("sel_read", rv, 16'h0001);
    readReg(5'h00, rv); checkOutput("sel_rdata", rv, 16'hB1B1);
    host_address = 5'h01; host_write = 1'b1; host_writedata = 16'h5A5A; #1;
    checkOutput("sel_w1", ch1_mgmt_write, 1);
    checkOutput("sel_w0", ch0_mgmt_write, 0);
    stepCycles(1); host_write = 1'b0;
    applyStimulus(5'h13, 1'b1, 16'hFFFF, 1'b0);
    readReg(5'h13, rv); checkOutput("reserved_rd", rv, 16'h0000);
    readReg(5'h11, rv); checkOutput("sel_kept", rv, 16'h0001);
    applyStimulus(5'h11, 1'b1, 16'h0000, 1'b0);

    // Reset during a grant drops it immediately
    ch0_request = REQ_CMD; ch1_request = REQ_RESET;
    stepCycles(2);
    checkOutput("pre_rst_irq", host_irq, 1);
    rst = 1'b1; host_address = 5'h02; host_write = 1'b1; #1;
    checkOutput("rst_irq", host_irq, 0);
    checkOutput("rst_w0", ch0_mgmt_write, 0);
    stepCycles(1); rst = 1'b0; host_write = 1'b0;
    stepCycles(1);
    readReg(5'h10, rv); checkOutput("post_rst_own0", rv, 16'h0024);
    applyStimulus(5'h05, 1'b1, 16'h0000, 1'b0);
    ch0_request = REQ_NONE;
    stepCycles(2);
    readReg(5'h10, rv); checkOutput("post_rst_own1", rv, 16'h0036);
    applyStimulus(5'h05, 1'b1, 16'h0000, 1'b0);
    ch1_request = REQ_NONE;
    stepCycles(2);

    // Idle grant: forced release only when the timeout is built in
    ch0_request = REQ_CMD;
    stepCycles(1);
    ch0_request = REQ_NONE;
    stepCycles(20);
`ifdef IDE_ARB_TIMEOUT_EN
    checkOutput("to_irq", host_irq, 0);
    readReg(5'h10, rv); checkOutput("to_flag", rv, 16'h0080);
    applyStimulus(5'h11, 1'b1, 16'h0100, 1'b0);
    readReg(5'h10, rv); checkOutput("to_clear", rv, 16'h0000);
`else
    checkOutput("noto_irq", host_irq, 1);
    readReg(5'h10, rv); checkOutput("noto_status", rv, 16'h0020);
    applyStimulus(5'h05, 1'b1, 16'h0000, 1'b0);
    stepCycles(1);
    checkOutput("noto_release", host_irq, 0);
`endif
    stepCycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ide_mgmt_arbiter.md
IDE_MGMT_ARBITER -- requirements
Module: ide_mgmt_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd10_000_000, host-inactivity cycles before forced release.
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports ch0_request, ch1_request  input  3 each  per-channel request code (000 none, 100 command, 101 data, 110 reset).
REQ-005 SHALL have ports host_address  input  5, host_write  input  1, host_writedata  input  16, host_read  input  1, host_readdata  output  16: the single host management port; bit 4 set selects arbiter registers.
REQ-006 SHALL have ports chN_mgmt_address  output  4, chN_mgmt_write  output  1, chN_mgmt_writedata  output  16, chN_mgmt_read  output  1 (N=0,1), and chN_mgmt_readdata  input  16.
REQ-007 SHALL have port host_irq  output  1, high while a grant awaits host service.

Function
REQ-008 SHALL implement states IDLE, GRANT, RELEASE.
REQ-009 IDLE: if either request is nonzero, SHALL go to GRANT next cycle, latching owner; if both are nonzero, owner = channel not granted last (rr_last), initial rr_last = 1 so ch0 wins first.
REQ-010 GRANT: host accesses with host_address[4]=0 SHALL forward to owner only; the other channel's write/read SHALL be 0.
REQ-011 GRANT: a forwarded write with host_address[3:0]=5 SHALL move the FSM to RELEASE the next cycle and set rr_last = owner.
REQ-012 RELEASE SHALL last exactly one cycle, ignore requests, then go to IDLE, so the owner's cleared request is not resampled.
REQ-013 IDLE: host accesses with host_address[4]=0 SHALL forward to the channel in sel (register 0x11 bit 0).
REQ-014 Writes with host_address[3:0]=6 SHALL broadcast to both channels in any state.
REQ-015 Forwarding SHALL be combinational, zero cycle latency; host_readdata for channel space SHALL mux chN_mgmt_readdata by a select registered on the read cycle.
REQ-016 Register 0x10, read-only, SHALL read {8'd0, timeout_flag, 1'b0, grant_valid, owner, 1'b0, live request code of owner}.
REQ-017 Register 0x11, read/write, bit 0 SHALL be sel; write 1 to bit 8 SHALL clear timeout_flag.
REQ-018 Reads of 0x12-0x1F SHALL return 0, and writes there SHALL be ignored.
REQ-019 host_irq SHALL equal (state==GRANT), registered; it SHALL drop the cycle RELEASE is entered.
REQ-020 A request that changes code during GRANT SHALL keep the grant; register 0x10 SHALL show the new code.
REQ-021 A request dropping to 000 during GRANT without a host write SHALL keep the grant until the address-5 write or timeout.

Reset
REQ-022 rst SHALL force state=IDLE, owner=0, rr_last=1, sel=0, timeout_flag=0, timer=0, host_irq=0, host_readdata=0.
REQ-023 rst mid-GRANT SHALL drop the grant immediately; forwarded strobes SHALL be 0 while rst is high.

Configuration
REQ-024 With IDE_ARB_TIMEOUT_EN defined, the timer SHALL count in GRANT, clear on any host access, and at TIMEOUT_CYCLES force RELEASE, set timeout_flag and set rr_last=owner.
REQ-025 Without IDE_ARB_TIMEOUT_EN, there SHALL be no timer; timeout_flag SHALL read 0 and GRANT SHALL persist until the address-5 write.

Structure
REQ-026 Shared package ide_pkg SHALL hold the request code constants (REQ_NONE, REQ_CMD, REQ_DATA, REQ_RESET), the FSM state typedef and the register offsets 0x10/0x11.
REQ-027 SHALL be a single module with no sub-module; the timer SHALL be inline under the macro.

Verification
REQ-028 ch0_request=100, ch1=000 -> GRANT owner 0 in 1 cycle, host_irq=1, 0x10 reads 0x0024.
REQ-029 Both request 100 from reset -> owner 0; host writes addr 5 -> RELEASE then GRANT owner 1; 0x10 reads 0x0034.
REQ-030 GRANT owner 1, host writes addr 2 data 0x1234 -> only ch1_mgmt_write=1 with writedata 0x1234; ch0_mgmt_write=0.
REQ-031 Host write addr 6 data 0x0289 in IDLE and in GRANT -> both chN_mgmt_write=1 same cycle.
REQ-032 IDE_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, grant with no host access -> RELEASE after 16 cycles, 0x10 bit 7=1; write 0x0100 to 0x11 -> bit 7=0.
REQ-033 rst pulsed mid-GRANT -> host_irq=0 and state IDLE in the same cycle; after release with ch1 pending, owner=0 is not regranted to ch1's loss.
